fir_dec_sched: RTL and testbench

Sequencing controller for the polyphase FIR lowpass decimator datapath. It does five things:
- accepts input samples over a valid/ready handshake;
- generates the per-sample strobe train (`clk_fs`, `clk_fs_d0`, `clk_fs_d1`, `clk_fs_d2`) and `en` that the FIR core needs;
- holds off new samples while the MAC pass runs;
- captures the FIR result and emits every D-th result as the decimated output;
- runs coefficient-RAM loads from a host stream.

It sits between the sample source and the FIR core, and is the only driver of the core's control inputs.

---
 rtl/fir_dec_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_fir_dec_sched.sv | 555 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_dec_sched.sv
// Sequencing controller for the polyphase FIR decimator core.
// Paces samples, drives core strobes, decimates results, loads coefficients.
module fir_dec_sched #(
  parameter int ORD         = 255,
  parameter int D           = 100,
  parameter int COEFF_SIZE  = 16,
  parameter int SAMPLE_SIZE = 16,
  parameter int MAC_NUM     = 1,
  parameter int MAC_LAT     = 2,
  localparam int MAC_SIZE   = (ORD + MAC_NUM) / MAC_NUM,
  localparam int AW         = $clog2(ORD + 1),
  localparam int OW         = SAMPLE_SIZE + COEFF_SIZE
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   en_in,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SAMPLE_SIZE-1:0] s_data,
  output logic                   m_valid,
  output logic [OW-1:0]          m_data,
  input  logic                   cl_start,
  input  logic                   cl_valid,
  output logic                   cl_ready,
  input  logic [COEFF_SIZE-1:0]  cl_data,
  output logic                   cl_done,
  output logic                   f_en,
  output logic                   f_clk_fs,
  output logic                   f_clk_fs_d0,
  output logic                   f_clk_fs_d1,
  output logic                   f_clk_fs_d2,
  output logic [SAMPLE_SIZE-1:0] f_din,
  input  logic [OW-1:0]          f_dout,
  output logic                   f_c_we,
  output logic [COEFF_SIZE-1:0]  f_c_in,
  output logic [AW-1:0]          f_c_addr
);

  localparam int MW   = MAC_SIZE + MAC_LAT;
  localparam int CW   = $clog2(MW) + 1;
  localparam int PW   = $clog2(D + 1);

  localparam logic [CW-1:0] STRB_LAST = CW'(3);
  localparam logic [CW-1:0] MACW_LAST = CW'(MW - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(D - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(ORD);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STRB,
    MACW,
    LOAD
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          phase_q, phase_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   pend_q, pend_d;
  logic [SAMPLE_SIZE-1:0] din_q, din_d;
  logic [OW-1:0]          mdata_q, mdata_d;
  logic                   mvalid_q, mvalid_d;
  logic                   cdone_q, cdone_d;
  logic [COEFF_SIZE-1:0]  cin_q, cin_d;
  logic [AW-1:0]          caddr_q, caddr_d;

  logic in_run;
  logic in_strb;
  logic in_load;
  logic accept;

  assign in_run  = (state_q == RUN);
  assign in_strb = (state_q == STRB);
  assign in_load = (state_q == LOAD);

  // Sample intake only while running with no load waiting.
  assign s_ready = in_run & en_in & ~pend_q;
  assign accept  = s_valid & s_ready;

  // Core strobes decode straight from the registered state and counter.
  always_comb begin
    f_en        = in_strb;
    f_clk_fs    = 1'b0;
    f_clk_fs_d0 = 1'b0;
    f_clk_fs_d1 = 1'b0;
    f_clk_fs_d2 = 1'b0;
    if (in_strb) begin
      unique case (cnt_q[1:0])
        2'd0: f_clk_fs    = 1'b1;
        2'd1: f_clk_fs_d0 = 1'b1;
        2'd2: f_clk_fs_d1 = 1'b1;
        2'd3: f_clk_fs_d2 = 1'b1;
        default: f_clk_fs = 1'b0;
      endcase
    end
  end

  assign cl_ready = in_load;
  assign f_c_we   = in_load;
  assign cl_done  = cdone_q;
  assign f_c_in   = cin_q;
  assign f_c_addr = caddr_q;
  assign f_din    = din_q;
  assign m_data   = mdata_q;
  assign m_valid  = mvalid_q;

  // Next-state, counters, capture and coefficient beat handling.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    pend_d   = pend_q;
    din_d    = din_q;
    mdata_d  = mdata_q;
    mvalid_d = 1'b0;
    cdone_d  = 1'b0;
    cin_d    = cin_q;
    caddr_d  = caddr_q;
    unique case (state_q)
      IDLE: begin
        if (cl_start || pend_q) begin
          state_d = LOAD;
        end else if (en_in) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cl_start) begin
          pend_d = 1'b1;
        end
        if (accept) begin
          din_d   = s_data;
          cnt_d   = '0;
          state_d = STRB;
        end else if (pend_q) begin
          state_d = LOAD;
        end else if (!en_in) begin
          state_d = IDLE;
        end
      end
      STRB: begin
        if (cl_start) begin
          pend_d = 1'b1;
        end
        if (cnt_q == STRB_LAST) begin
          cnt_d   = '0;
          state_d = MACW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MACW: begin
        if (cl_start) begin
          pend_d = 1'b1;
        end
        if (cnt_q == MACW_LAST) begin
          cnt_d   = '0;
          mdata_d = f_dout;
          state_d = RUN;
          if (phase_q == PH_LAST) begin
            mvalid_d = 1'b1;
            phase_d  = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD: begin
        if (cl_valid) begin
          cin_d   = cl_data;
          caddr_d = addr_q;
          if (addr_q == ADDR_LAST) begin
            addr_d  = '0;
            phase_d = '0;
            pend_d  = 1'b0;
            cdone_d = 1'b1;
            state_d = en_in ? RUN : IDLE;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      phase_q  <= '0;
      addr_q   <= '0;
      pend_q   <= 1'b0;
      din_q    <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      cdone_q  <= 1'b0;
      cin_q    <= '0;
      caddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      pend_q   <= pend_d;
      din_q    <= din_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      cdone_q  <= cdone_d;
      cin_q    <= cin_d;
      caddr_q  <= caddr_d;
    end
  end

endmodule

// File: tb/tb_fir_dec_sched.sv
// Bench for fir_dec_sched: ORD=7, MAC_NUM=2, D=3, MAC_LAT=2.
// Timing expectations come from accept-relative cycle arithmetic.
module tb_fir_dec_sched;

  localparam int ORD     = 7;
  localparam int D       = 3;
  localparam int MAC_NUM = 2;
  localparam int MAC_LAT = 2;
  localparam int CS      = 16;
  localparam int SS      = 16;
  localparam int MS      = (ORD + MAC_NUM) / MAC_NUM;
  localparam int P       = MS + MAC_LAT + 5;
  localparam int AW      = 3;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          en_in = 1'b0;
  logic          s_valid = 1'b0;
  logic [SS-1:0] s_data = '0;
  logic          cl_start = 1'b0;
  logic          cl_valid = 1'b0;
  logic [CS-1:0] cl_data = '0;
  logic [31:0]   f_dout = '0;

  logic          s_ready;
  logic          m_valid;
  logic [31:0]   m_data;
  logic          cl_ready;
  logic          cl_done;
  logic          f_en;
  logic          f_clk_fs;
  logic          f_clk_fs_d0;
  logic          f_clk_fs_d1;
  logic          f_clk_fs_d2;
  logic [SS-1:0] f_din;
  logic          f_c_we;
  logic [CS-1:0] f_c_in;
  logic [AW-1:0] f_c_addr;

  fir_dec_sched #(
    .ORD(ORD),
    .D(D),
    .COEFF_SIZE(CS),
    .SAMPLE_SIZE(SS),
    .MAC_NUM(MAC_NUM),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .en_in(en_in),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_data(m_data),
    .cl_start(cl_start),
    .cl_valid(cl_valid),
    .cl_ready(cl_ready),
    .cl_data(cl_data),
    .cl_done(cl_done),
    .f_en(f_en),
    .f_clk_fs(f_clk_fs),
    .f_clk_fs_d0(f_clk_fs_d0),
    .f_clk_fs_d1(f_clk_fs_d1),
    .f_clk_fs_d2(f_clk_fs_d2),
    .f_din(f_din),
    .f_dout(f_dout),
    .f_c_we(f_c_we),
    .f_c_in(f_c_in),
    .f_c_addr(f_c_addr)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] dh [0:2047];

  function automatic logic [76:0] outs();
    return {s_ready, m_valid, m_data, cl_ready, cl_done,
            f_en, f_clk_fs, f_clk_fs_d0, f_clk_fs_d1,
            f_clk_fs_d2, f_din, f_c_we, f_c_in, f_c_addr};
  endfunction

  function automatic logic [3:0] strb();
    return {f_clk_fs_d2, f_clk_fs_d1, f_clk_fs_d0, f_clk_fs};
  endfunction

  function automatic logic [3:0] exp_strb(input int k);
    logic [3:0] one;
    one = 4'b0001;
    if (k >= 1 && k <= 4) return one << (k - 1);
    return 4'b0000;
  endfunction

  // Advance to 1 time unit after the next rising edge; new random core result.
  task automatic nxt();
    @(posedge clk);
    #1;
    cyc++;
    f_dout = $urandom;
    dh[cyc] = f_dout;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    en_in = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    cl_start = 1'b0;
    cl_valid = 1'b0;
    cl_data = '0;
    #2;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    cyc = 1;
    f_dout = $urandom;
    dh[1] = f_dout;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    en_in = 1'b1;
    s_valid = 1'b1;
    #2;
    n_run++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got %h exp 0", outs());
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #4;
      n_run++;
      if (outs() !== '0) begin
        n_fail++;
        $display("FAIL idle_outs got %h exp 0", outs());
      end
      nxt();
    end
    en_in = 1'b1;
    #4;
    n_run++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL idle_en_outs got %h exp 0", outs());
    end
    nxt();
    #4;
    n_run++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL run_ready got %b exp 1", s_ready);
    end
  endtask

  task automatic test_single();
    int c0;
    do_reset();
    en_in = 1'b1;
    #4;
    n_run++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_c1 got %b exp 0", s_ready);
    end
    nxt();
    s_valid = 1'b1;
    s_data = 16'h1234;
    #4;
    n_run++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_c2 got %b exp 1", s_ready);
    end
    c0 = cyc;
    nxt();
    s_valid = 1'b0;
    s_data = 16'hdead;
    for (int k = 1; k <= P; k++) begin
      #4;
      n_run++;
      if (strb() !== exp_strb(k) || f_en !== (k <= 4)) begin
        n_fail++;
        $display("FAIL single_strb k=%0d got %b/%b exp %b/%b",
                 k, strb(), f_en, exp_strb(k), k <= 4);
      end
      n_run++;
      if (f_din !== 16'h1234) begin
        n_fail++;
        $display("FAIL single_din k=%0d got %h exp 1234", k, f_din);
      end
      n_run++;
      if (s_ready !== (k == P)) begin
        n_fail++;
        $display("FAIL single_ready k=%0d got %b exp %b",
                 k, s_ready, k == P);
      end
      if (k == P) begin
        n_run++;
        if (m_data !== dh[c0 + P - 1] || m_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_cap got %h/%b exp %h/0",
                   m_data, m_valid, dh[c0 + P - 1]);
        end
      end else begin
        nxt();
      end
    end
  endtask

  task automatic test_stream(input bit hold, input int n);
    int last;
    int ready_at;
    int nres;
    int nacc;
    int nmv;
    int k;
    logic [15:0] din_e;
    logic [31:0] md_e;
    logic exp_mv;
    do_reset();
    en_in = 1'b1;
    last = -1000;
    ready_at = 2;
    nres = 0;
    nacc = 0;
    nmv = 0;
    din_e = '0;
    md_e = '0;
    for (int c = 1; c <= n; c++) begin
      s_valid = hold ? 1'b1 : ($urandom_range(2) == 0);
      s_data = 16'($urandom);
      #4;
      k = c - last;
      if (k == P) begin
        md_e = dh[last + P - 1];
        exp_mv = ((nres % D) == D - 1);
        nres++;
      end else begin
        exp_mv = 1'b0;
      end
      n_run++;
      if (s_ready !== (c >= ready_at)) begin
        n_fail++;
        $display("FAIL strm_ready c=%0d got %b exp %b",
                 c, s_ready, c >= ready_at);
      end
      n_run++;
      if (strb() !== exp_strb(k) || f_din !== din_e) begin
        n_fail++;
        $display("FAIL strm_strb c=%0d got %b/%h exp %b/%h",
                 c, strb(), f_din, exp_strb(k), din_e);
      end
      n_run++;
      if (m_valid !== exp_mv || m_data !== md_e) begin
        n_fail++;
        $display("FAIL strm_out c=%0d got %b/%h exp %b/%h",
                 c, m_valid, m_data, exp_mv, md_e);
      end
      if (s_valid && s_ready) nacc++;
      if (m_valid) nmv++;
      if (s_valid && c >= ready_at) begin
        last = c;
        din_e = s_data;
        ready_at = c + P;
      end
      nxt();
    end
    s_valid = 1'b0;
    if (hold) begin
      n_run++;
      if (nacc != 10 || nmv != 3) begin
        n_fail++;
        $display("FAIL strm_counts got acc=%0d mv=%0d exp acc=10 mv=3",
                 nacc, nmv);
      end
    end
  endtask

  task automatic test_load();
    int b;
    int g;
    int first_mv;
    int nmv;
    bit got;
    do_reset();
    en_in = 1'b1;
    nxt();
    s_valid = 1'b1;
    s_data = 16'($urandom);
    #4;
    nxt();
    s_valid = 1'b0;
    repeat (P - 1) nxt();
    cl_start = 1'b1;
    #4;
    nxt();
    cl_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #4;
      if (cl_ready === 1'b1) got = 1'b1;
      else nxt();
    end
    n_run++;
    if (!got) begin
      n_fail++;
      $display("FAIL load_enter got cl_ready=%b exp 1", cl_ready);
    end
    n_run++;
    if (f_c_we !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_first got we=%b rdy=%b exp 1/0", f_c_we, s_ready);
    end
    nxt();
    b = 0;
    g = 0;
    while (b <= ORD && g < 100) begin
      cl_valid = ($urandom_range(3) != 0);
      cl_data = cl_valid ? 16'(16'h10 + b) : 16'($urandom);
      cl_start = ($urandom_range(5) == 0);
      #4;
      n_run++;
      if (f_c_we !== 1'b1 || cl_ready !== 1'b1 ||
          s_ready !== 1'b0 || cl_done !== 1'b0) begin
        n_fail++;
        $display("FAIL load_ctl b=%0d got we=%b crdy=%b srdy=%b done=%b",
                 b, f_c_we, cl_ready, s_ready, cl_done);
      end
      if (b > 0) begin
        n_run++;
        if (f_c_addr !== AW'(b - 1) || f_c_in !== 16'(16'h10 + b - 1)) begin
          n_fail++;
          $display("FAIL load_beat b=%0d got %0d/%h exp %0d/%h",
                   b, f_c_addr, f_c_in, b - 1, 16'h10 + b - 1);
        end
      end
      if (cl_valid) b++;
      nxt();
      g++;
    end
    cl_valid = 1'b0;
    cl_start = 1'b0;
    n_run++;
    if (b != ORD + 1) begin
      n_fail++;
      $display("FAIL load_beats got %0d exp %0d", b, ORD + 1);
    end
    #4;
    n_run++;
    if (f_c_we !== 1'b0 || cl_done !== 1'b1 ||
        f_c_addr !== AW'(ORD) || f_c_in !== 16'h17) begin
      n_fail++;
      $display("FAIL load_done got we=%b done=%b a=%0d d=%h exp 0/1/7/0017",
               f_c_we, cl_done, f_c_addr, f_c_in);
    end
    nxt();
    s_valid = 1'b1;
    first_mv = -1;
    nmv = 0;
    for (int r = 0; r <= 3 * P + 1; r++) begin
      s_data = 16'($urandom);
      #4;
      if (r == 0) begin
        n_run++;
        if (cl_done !== 1'b0 || s_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL load_after got done=%b rdy=%b exp 0/1",
                   cl_done, s_ready);
        end
      end
      if (m_valid === 1'b1) begin
        nmv++;
        if (first_mv < 0) first_mv = r;
      end
      nxt();
    end
    s_valid = 1'b0;
    n_run++;
    if (first_mv != 3 * P || nmv != 1) begin
      n_fail++;
      $display("FAIL load_phase got first=%0d n=%0d exp first=%0d n=1",
               first_mv, nmv, 3 * P);
    end
  endtask

  task automatic test_collide_load();
    int c0;
    bit got;
    do_reset();
    en_in = 1'b1;
    nxt();
    s_valid = 1'b1;
    s_data = 16'h0abc;
    #4;
    c0 = cyc;
    nxt();
    s_valid = 1'b0;
    for (int k = 1; k <= P; k++) begin
      cl_start = (k == 6);
      #4;
      n_run++;
      if (cl_ready !== 1'b0 || strb() !== exp_strb(k)) begin
        n_fail++;
        $display("FAIL cl_defer k=%0d got crdy=%b strb=%b exp 0/%b",
                 k, cl_ready, strb(), exp_strb(k));
      end
      if (k == P) begin
        n_run++;
        if (m_data !== dh[c0 + P - 1] || s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL cl_cap got %h/%b exp %h/0",
                   m_data, s_ready, dh[c0 + P - 1]);
        end
      end
      nxt();
    end
    cl_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      #4;
      if (cl_ready === 1'b1) got = 1'b1;
      else nxt();
    end
    n_run++;
    if (!got) begin
      n_fail++;
      $display("FAIL cl_enter got cl_ready=%b exp 1", cl_ready);
    end
  endtask

  task automatic test_collide_en();
    int c0;
    do_reset();
    en_in = 1'b1;
    nxt();
    s_valid = 1'b1;
    s_data = 16'h5a5a;
    #4;
    c0 = cyc;
    nxt();
    s_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      en_in = (k < 2 || k >= 15);
      s_valid = 1'b1;
      #4;
      if (k <= 4) begin
        n_run++;
        if (strb() !== exp_strb(k) || f_en !== 1'b1) begin
          n_fail++;
          $display("FAIL en_strb k=%0d got %b/%b exp %b/1",
                   k, strb(), f_en, exp_strb(k));
        end
      end
      if (k == P) begin
        n_run++;
        if (m_data !== dh[c0 + P - 1]) begin
          n_fail++;
          $display("FAIL en_cap got %h exp %h", m_data, dh[c0 + P - 1]);
        end
      end
      n_run++;
      if (s_ready !== (k == 16)) begin
        n_fail++;
        $display("FAIL en_ready k=%0d got %b exp %b", k, s_ready, k == 16);
      end
      if (k < 16) nxt();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset_load();
    do_reset();
    cl_start = 1'b1;
    #4;
    nxt();
    cl_start = 1'b0;
    #4;
    n_run++;
    if (cl_ready !== 1'b1 || f_c_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rl_enter got %b/%b exp 1/1", cl_ready, f_c_we);
    end
    nxt();
    for (int i = 0; i < 4; i++) begin
      cl_valid = 1'b1;
      cl_data = 16'(16'h20 + i);
      nxt();
    end
    cl_valid = 1'b0;
    n_run++;
    if (f_c_addr !== 3'd3 || f_c_in !== 16'h23) begin
      n_fail++;
      $display("FAIL rl_beat3 got %0d/%h exp 3/0023", f_c_addr, f_c_in);
    end
    nrst = 1'b0;
    #1;
    n_run++;
    if (f_c_we !== 1'b0 || f_c_addr !== '0 ||
        cl_ready !== 1'b0 || f_c_in !== '0) begin
      n_fail++;
      $display("FAIL rl_async got we=%b a=%0d crdy=%b d=%h exp 0/0/0/0",
               f_c_we, f_c_addr, cl_ready, f_c_in);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    #4;
    n_run++;
    if (cl_ready !== 1'b0 || f_c_we !== 1'b0 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rl_idle got %b/%b/%b exp 0/0/0",
               cl_ready, f_c_we, s_ready);
    end
    nxt();
    cl_start = 1'b1;
    #4;
    nxt();
    cl_start = 1'b0;
    cl_valid = 1'b1;
    cl_data = 16'h0055;
    #4;
    nxt();
    cl_valid = 1'b0;
    #4;
    n_run++;
    if (f_c_addr !== '0 || f_c_in !== 16'h0055) begin
      n_fail++;
      $display("FAIL rl_restart got %0d/%h exp 0/0055", f_c_addr, f_c_in);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream(1'b1, 105);
    test_stream(1'b0, 160);
    test_load();
    test_collide_load();
    test_collide_en();
    test_reset_load();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
